eae_unit: RTL
=============

Name: eae_unit

Overview:
- Parametrised extended-arithmetic engine. It runs multi-cycle MUY, DVI, NMI, SHL, ASR and LSR on the AC:MQ double register pair.
- Sits beside the accumulator datapath. The CPU sequencer loads AC, MQ, L and the memory operand, pulses start, and stalls until done.
- It then writes ac_out, mq_out, l_out and sc_out back.
- All vectors are MSB-first: bit 0 is the most significant bit.

Parameters:
- WIDTH, 12, word width of AC, MQ and operand.
- SC_WIDTH, 5, step-counter width. Must satisfy 2^SC_WIDTH >= 2*WIDTH.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request. Sampled only in IDLE.
- op  in  4  operation code: 0000 NOP, 0001 MUY, 0010 DVI, 0011 NMI, 0100 SHL, 0101 ASR, 0110 LSR, 1000 DPIC, 1001 DCM, 1010 DPSZ
- ac_in  in  WIDTH  AC at start
- mq_in  in  WIDTH  MQ at start
- l_in  in  1  link at start
- operand  in  WIDTH  memory operand: multiplier/divisor, or shift count in its low SC_WIDTH bits
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; results valid on the same cycle
- skip  out  1  DPSZ result; valid with done
- ac_out  out  WIDTH  AC result
- mq_out  out  WIDTH  MQ result
- l_out  out  1  link result
- sc_out  out  SC_WIDTH  step counter

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done and skip = 0; ac_out, mq_out, l_out and sc_out = 0. Reset mid-operation abandons the operation; no done pulse follows.
- FSM states: IDLE, LOAD, RUN, FIN.
  - IDLE: start=1 latches all inputs and moves to LOAD. start while busy is ignored.
  - LOAD: set up the step count and operand, then go to RUN. This step takes 1 cycle.
  - RUN: one step per cycle until the count is exhausted or the terminate condition holds, then go to FIN.
  - FIN: done=1, busy=0, registers updated, return to IDLE.
- MUY: {AC,MQ} = MQ*operand + AC, unsigned. Shift-and-add, one multiplier bit per cycle, WIDTH RUN cycles. L=0. sc_out=0.
  - Latency start->done = WIDTH+2 cycles (14 at WIDTH=12).
- DVI: dividend {AC,MQ}, divisor operand. Restoring division, WIDTH RUN cycles. Result MQ=quotient, AC=remainder, L=0.
  - Overflow: if AC >= operand at LOAD (this includes divisor 0), skip RUN and go to FIN with L=1 and AC, MQ unchanged. Latency is 2 cycles.
- NMI: shift {AC,MQ} left one bit per cycle. sc counts shifts, starting from 0.
  - Stop when AC[0] != AC[1], or {AC,MQ} == 0, or {AC,MQ} == {100..0, 0}. The stop check runs before each shift, so an already-normalised input gives 0 shifts.
  - L receives each bit shifted out of AC[0].
- SHL: shift left operand[WIDTH-SC_WIDTH:WIDTH-1]+1 places. Zero fills MQ[WIDTH-1]; L receives AC[0]. sc ends at 0.
- ASR: shift right the same count. AC[0] is replicated; L=AC[0] on each step; MQ[WIDTH-1] is discarded.
- LSR: same as ASR but zero fill, and L=0.
- Shift counts run from 1 to 2^SC_WIDTH. Counts beyond 2*WIDTH continue shifting, giving all-zero (LSR) or all-sign (ASR) results.
- NOP, and any undefined op: regs unchanged, done 2 cycles after start.
- skip = 0 except on DPSZ.
- Outputs hold their values between operations.

Optional Feature:
- EAE_DOUBLE_EN defined: DPIC, DCM and DPSZ are enabled. Each has LOAD plus one RUN cycle.
  - DPIC: {L,AC,MQ} = {AC,MQ}+1, with L = carry out of AC[0].
  - DCM: {AC,MQ} = -{AC,MQ}, with L = carry of ~{AC,MQ}+1.
  - DPSZ: skip = ({AC,MQ}==0); registers unchanged.
- EAE_DOUBLE_EN undefined: opcodes 1000-1010 behave as NOP; skip is always 0.

Test Plan:
- MUY: AC=0o0003, MQ=0o0012, operand=0o0005 -> AC=0o0000, MQ=0o0065, L=0; done exactly 14 cycles after start.
- DVI: AC=0o0000, MQ=0o0144, operand=0o0007 -> MQ=0o0016, AC=0o0002, L=0.
- DVI overflow: AC=0o0010, MQ=0o1234, operand=0o0007 -> L=1, AC=0o0010, MQ=0o1234; done 2 cycles after start.
- NMI: AC=0o0000, MQ=0o0400 -> AC=0o2000, MQ=0o0000, sc_out=14.
- NMI, second case: AC=0o4000, MQ=0 -> 0 shifts, sc_out=0.
- ASR: AC=0o4000, MQ=0, operand=0o0002 -> AC=0o7400, MQ=0, L=1.
- LSR with the same inputs -> AC=0o0400, L=0.
- Reset mid-MUY: assert reset at RUN cycle 5 -> outputs 0 immediately, no done pulse. A new MUY then completes normally.
- With EAE_DOUBLE_EN: DPIC on AC=0o7777, MQ=0o7777 -> AC=0, MQ=0, L=1, then DPSZ -> skip=1.
- Without EAE_DOUBLE_EN: the same DPIC leaves the registers unchanged.

Source files
------------

// File: rtl/eae_unit.sv
// Extended-arithmetic engine: multi-cycle MUY/DVI/NMI/SHL/ASR/LSR on the AC:MQ pair.
// Define EAE_DOUBLE_EN to add the DPIC/DCM/DPSZ double-word operations.
module eae_unit #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned SC_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          op,
  input  logic [WIDTH-1:0]    ac_in,
  input  logic [WIDTH-1:0]    mq_in,
  input  logic                l_in,
  input  logic [WIDTH-1:0]    operand,
  output logic                busy,
  output logic                done,
  output logic                skip,
  output logic [WIDTH-1:0]    ac_out,
  output logic [WIDTH-1:0]    mq_out,
  output logic                l_out,
  output logic [SC_WIDTH-1:0] sc_out
);

  localparam int unsigned CntW = SC_WIDTH + 1;

  localparam logic [3:0] OpMuy  = 4'b0001;
  localparam logic [3:0] OpDvi  = 4'b0010;
  localparam logic [3:0] OpNmi  = 4'b0011;
  localparam logic [3:0] OpShl  = 4'b0100;
  localparam logic [3:0] OpAsr  = 4'b0101;
  localparam logic [3:0] OpLsr  = 4'b0110;
`ifdef EAE_DOUBLE_EN
  localparam logic [3:0] OpDpic = 4'b1000;
  localparam logic [3:0] OpDcm  = 4'b1001;
  localparam logic [3:0] OpDpsz = 4'b1010;
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StFin} state_e;

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [WIDTH-1:0]    ac_q, ac_d, mq_q, mq_d, opd_q, opd_d;
  logic                l_q, l_d;
  logic [SC_WIDTH-1:0] sc_q, sc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                skip_d;
  logic                skip_q;

  // Datapath temporaries
  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      rem;
  logic [WIDTH-1:0]    diff;
  logic                ge;
  logic                nmi_stop;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ac_d     = ac_q;
    mq_d     = mq_q;
    opd_d    = opd_q;
    l_d      = l_q;
    sc_d     = sc_q;
    cnt_d    = cnt_q;
    skip_d   = 1'b0;
    sum      = {1'b0, ac_q} + (mq_q[0] ? {1'b0, opd_q} : '0);
    rem      = {ac_q, mq_q[WIDTH-1]};
    ge       = (rem >= {1'b0, opd_q});
    // rem < 2*opd here, so the true difference always fits in WIDTH bits
    diff     = rem[WIDTH-1:0] - opd_q;
    nmi_stop = (ac_q[WIDTH-1] != ac_q[WIDTH-2]) || ({ac_q, mq_q} == '0) ||
               ({ac_q, mq_q} == {1'b1, {(2*WIDTH-1){1'b0}}});

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          ac_d    = ac_in;
          mq_d    = mq_in;
          l_d     = l_in;
          opd_d   = operand;
          sc_d    = sc_out;
          state_d = StLoad;
        end
      end

      StLoad: begin
        state_d = StRun;
        case (op_q)
          OpMuy: begin
            cnt_d = CntW'(WIDTH);
            l_d   = 1'b0;
            sc_d  = '0;
          end
          OpDvi: begin
            if (ac_q >= opd_q) begin
              l_d     = 1'b1;
              state_d = StFin;
            end else begin
              cnt_d = CntW'(WIDTH);
              l_d   = 1'b0;
              sc_d  = '0;
            end
          end
          OpNmi: sc_d = '0;
          OpShl, OpAsr, OpLsr: begin
            cnt_d = {1'b0, opd_q[SC_WIDTH-1:0]} + CntW'(1);
            sc_d  = '0;
          end
`ifdef EAE_DOUBLE_EN
          OpDpic, OpDcm, OpDpsz: ;
`endif
          default: state_d = StFin;
        endcase
      end

      StRun: begin
        case (op_q)
          OpMuy, OpDvi, OpShl, OpAsr, OpLsr: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) state_d = StFin;
            case (op_q)
              OpMuy: {ac_d, mq_d} = {sum, mq_q[WIDTH-1:1]};
              OpDvi: begin
                ac_d = ge ? diff : rem[WIDTH-1:0];
                mq_d = {mq_q[WIDTH-2:0], ge};
              end
              OpShl:   {l_d, ac_d, mq_d} = {ac_q, mq_q, 1'b0};
              OpAsr:   {l_d, ac_d, mq_d} = {ac_q[WIDTH-1], ac_q[WIDTH-1], ac_q,
                                            mq_q[WIDTH-1:1]};
              default: {l_d, ac_d, mq_d} = {2'b00, ac_q, mq_q[WIDTH-1:1]};
            endcase
          end
          OpNmi: begin
            // Stop test precedes the shift, so normalised input costs no shifts
            if (nmi_stop) begin
              state_d = StFin;
            end else begin
              {l_d, ac_d, mq_d} = {ac_q, mq_q, 1'b0};
              sc_d              = sc_q + SC_WIDTH'(1);
            end
          end
`ifdef EAE_DOUBLE_EN
          OpDpic: begin
            {l_d, ac_d, mq_d} = {1'b0, ac_q, mq_q} + (2*WIDTH+1)'(1);
            state_d           = StFin;
          end
          OpDcm: begin
            {l_d, ac_d, mq_d} = {1'b0, ~ac_q, ~mq_q} + (2*WIDTH+1)'(1);
            state_d           = StFin;
          end
          OpDpsz: begin
            skip_d  = ({ac_q, mq_q} == '0);
            state_d = StFin;
          end
`endif
          default: state_d = StFin;
        endcase
      end

      StFin: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      ac_q    <= '0;
      mq_q    <= '0;
      opd_q   <= '0;
      l_q     <= 1'b0;
      sc_q    <= '0;
      cnt_q   <= '0;
      ac_out  <= '0;
      mq_out  <= '0;
      l_out   <= 1'b0;
      sc_out  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ac_q    <= ac_d;
      mq_q    <= mq_d;
      opd_q   <= opd_d;
      l_q     <= l_d;
      sc_q    <= sc_d;
      cnt_q   <= cnt_d;
      // Results become visible together with the done pulse
      if (state_d == StFin) begin
        ac_out <= ac_d;
        mq_out <= mq_d;
        l_out  <= l_d;
        sc_out <= sc_d;
        skip_q <= skip_d;
      end
    end
  end

  assign busy = (state_q == StLoad) || (state_q == StRun);
  assign done = (state_q == StFin);
  assign skip = skip_q;

endmodule
